adas_sensor_filter: RTL and testbench
=====================================

ADAS_SENSOR_FILTER -- requirements
Module: adas_sensor_filter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive samples needed to change a filtered detect output (legal range >= 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: heartbeat-free cycles that declare a sensor dead (legal range >= 2).
REQ-003 SHALL have parameter RECOVER_CYCLES, default 16: fault-free cycles required before ADAS is re-enabled (legal range >= 1, < TIMEOUT_CYCLES).
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port camera_raw  input  1  unfiltered camera object-in-front detect.
REQ-007 SHALL have port radar_raw  input  1  unfiltered radar object-approaching detect.
REQ-008 SHALL have port camera_alive  input  1  one-cycle camera heartbeat pulse.
REQ-009 SHALL have port radar_alive  input  1  one-cycle radar heartbeat pulse.
REQ-010 SHALL have port error_clear  input  1  driver/service request to leave FAULT.
REQ-011 SHALL have port camera  output  1  filtered camera detect, feeding the ADAS brake-decision stage.
REQ-012 SHALL have port radar  output  1  filtered radar detect, feeding the ADAS brake-decision stage.
REQ-013 SHALL have port adas_error  output  1  ADAS unavailable; high while the state is not OK.

Function
REQ-014 SHALL keep, per channel, a filtered bit and a debounce counter; on each edge the counter clears when raw equals filtered, else increments.
REQ-015 SHALL update the filtered bit to the raw value on the DEBOUNCE_CYCLES-th consecutive edge sampling raw != filtered, and clear the counter on that edge.
REQ-016 SHALL restart the debounce count at 0 if raw returns to the filtered value before the count completes (glitch rejection).
REQ-017 SHALL keep, per sensor, a watchdog counter: cleared on an edge sampling alive=1, otherwise incremented, saturating at TIMEOUT_CYCLES.
REQ-018 SHALL assert an internal timeout for a sensor while its watchdog counter equals TIMEOUT_CYCLES; any_timeout = camera OR radar timeout.
REQ-019 SHALL give an alive pulse priority over saturation: a pulse on the edge the counter would reach TIMEOUT_CYCLES clears it.
REQ-020 SHALL implement a state machine with states OK, FAULT, RECOVER.
REQ-021 SHALL transition OK -> FAULT on an edge where any_timeout is high.
REQ-022 SHALL transition FAULT -> RECOVER on an edge where error_clear is high and any_timeout is low; otherwise it SHALL stay in FAULT.
REQ-023 SHALL in RECOVER count edges, and transition RECOVER -> FAULT on any edge with any_timeout high (the FAULT transition wins over completion).
REQ-024 SHALL transition RECOVER -> OK on the RECOVER_CYCLES-th edge in RECOVER with any_timeout low.
REQ-025 SHALL ignore error_clear in OK and RECOVER.
REQ-026 SHALL drive adas_error = 1 in FAULT and RECOVER and 0 in OK, decoded from the registered state.
REQ-027 SHALL drive camera = filtered camera AND (state == OK), and radar likewise.
REQ-028 SHALL keep the debounce filters running in all states, so the outputs reflect the current filtered value on entry to OK.
REQ-029 SHALL size all counters to hold their parameter value without overflow.

Reset
REQ-030 SHALL, while reset is high, immediately force state = RECOVER, clear all counters and filtered bits, and drive camera = 0, radar = 0, adas_error = 1.
REQ-031 SHALL, after reset is released, require RECOVER_CYCLES fault-free edges before adas_error falls.
REQ-032 SHALL, on reset asserted mid-operation in any state, abandon that operation and apply REQ-030.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8, RECOVER_CYCLES=4)
REQ-033 SHALL cover: release reset with alive pulses every 3 cycles -> adas_error=1 for 4 edges, then 0; camera=radar=0 throughout.
REQ-034 SHALL cover: in OK, camera_raw 0->1 held -> camera rises on the 4th edge sampling 1; a 3-cycle pulse followed by 0 -> camera stays 0.
REQ-035 SHALL cover: in OK, radar_alive stops -> adas_error rises on the 9th edge after the last edge sampling alive=1, and camera/radar drop to 0 together with it.
REQ-036 SHALL cover: in FAULT with heartbeats resumed, error_clear pulse -> RECOVER, then OK 4 edges later; error_clear while a timeout is still present -> stays FAULT.
REQ-037 SHALL cover: in RECOVER, camera timeout on the 3rd edge -> FAULT, adas_error stays 1 continuously.
REQ-038 SHALL cover: reset asserted mid-debounce in OK with camera=1 -> camera=0 and adas_error=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/adas_sensor_filter.sv
// Camera/radar detect conditioning for the ADAS brake path: per-channel debounce,
// per-sensor heartbeat watchdogs and an OK/FAULT/RECOVER availability state machine.
module adas_sensor_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int RECOVER_CYCLES  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic camera_raw,
  input  logic radar_raw,
  input  logic camera_alive,
  input  logic radar_alive,
  input  logic error_clear,
  output logic camera,
  output logic radar,
  output logic adas_error
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Index 0 is the camera, index 1 the radar, for both filters and watchdogs.
  logic [1:0]      raw_vec;
  logic [1:0]      alive_vec;
  logic [1:0]      filt;
  logic [DB_W-1:0] db_cnt [2];
  logic [WD_W-1:0] wd_cnt [2];
  logic [1:0]      timeout;
  logic            any_timeout;
  state_t          state;
  logic [RC_W-1:0] rec_cnt;

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + WD_W'(1);
  endfunction

  assign raw_vec   = {radar_raw, camera_raw};
  assign alive_vec = {radar_alive, camera_alive};

  // Debounce: a raw/filtered disagreement must persist DEBOUNCE_CYCLES edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_vec[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= raw_vec[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Watchdogs: a heartbeat always wins over reaching saturation on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) wd_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wd_cnt[i] <= alive_vec[i] ? '0 : wd_sat_inc(wd_cnt[i]);
      end
    end
  end

  assign timeout[0]  = (wd_cnt[0] == WD_MAX);
  assign timeout[1]  = (wd_cnt[1] == WD_MAX);
  assign any_timeout = |timeout;

  // Availability state machine; reset lands in RECOVER so a clean run-in is required.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_RECOVER;
      rec_cnt <= '0;
    end else begin
      case (state)
        ST_OK: begin
          if (any_timeout) state <= ST_FAULT;
        end
        ST_FAULT: begin
          if (error_clear && !any_timeout) begin
            state   <= ST_RECOVER;
            rec_cnt <= '0;
          end
        end
        ST_RECOVER: begin
          if (any_timeout) begin
            state   <= ST_FAULT;
            rec_cnt <= '0;
          end else if (rec_cnt == RC_LAST) begin
            state   <= ST_OK;
            rec_cnt <= '0;
          end else begin
            rec_cnt <= rec_cnt + RC_W'(1);
          end
        end
        default: begin
          state   <= ST_FAULT;
          rec_cnt <= '0;
        end
      endcase
    end
  end

  assign adas_error = (state != ST_OK);
  assign camera     = filt[0] & (state == ST_OK);
  assign radar      = filt[1] & (state == ST_OK);

endmodule

// File: tb/tb_adas_sensor_filter.sv
// Directed bench for adas_sensor_filter with DEBOUNCE=4, TIMEOUT=8, RECOVER=4;
// outputs are compared as the triple {adas_error, camera, radar}.
module tb_adas_sensor_filter;

  logic clock = 1'b0;
  logic reset;
  logic camera_raw, radar_raw;
  logic camera_alive, radar_alive;
  logic error_clear;
  logic camera, radar, adas_error;

  int vectors     = 0;
  int miscompares = 0;
  int hb_phase    = 2;
  logic cam_hb_en = 1'b0;
  logic rad_hb_en = 1'b0;

  adas_sensor_filter #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (8),
    .RECOVER_CYCLES (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .camera_raw  (camera_raw),
    .radar_raw   (radar_raw),
    .camera_alive(camera_alive),
    .radar_alive (radar_alive),
    .error_clear (error_clear),
    .camera      (camera),
    .radar       (radar),
    .adas_error  (adas_error)
  );

  always #5 clock = ~clock;

  // Drive heartbeats (every third edge when enabled), then advance exactly one edge.
  task automatic tick();
    hb_phase     = (hb_phase == 2) ? 0 : hb_phase + 1;
    camera_alive = cam_hb_en && (hb_phase == 0);
    radar_alive  = rad_hb_en && (hb_phase == 0);
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] expected);
    logic [2:0] observed;
    observed = {adas_error, camera, radar};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: {adas_error,camera,radar} observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Tick until the edge just taken sampled a heartbeat pulse (at most 3 edges).
  task automatic tick_to_pulse();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (hb_phase == 0) break;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete, observed hang expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    reset = 1'b1; camera_raw = 1'b0; radar_raw = 1'b0;
    camera_alive = 1'b0; radar_alive = 1'b0; error_clear = 1'b0;
    #2;
    check("reset_async_t2", 3'b100);
    @(posedge clock); #1;
    check("reset_held_edge", 3'b100);

    // Release reset with heartbeats every 3 cycles: 4 RECOVER edges then OK.
    reset = 1'b0; cam_hb_en = 1'b1; rad_hb_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(); check($sformatf("startup_recover_e%0d", k), 3'b100);
    end
    tick(); check("startup_ok_e4", 3'b000);

    // Camera debounce rise, fall, and 3-cycle glitch rejection.
    camera_raw = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(); check($sformatf("cam_rise_wait_e%0d", k), 3'b000);
    end
    tick(); check("cam_rise_e4", 3'b010);
    camera_raw = 1'b0;
    repeat (3) tick();
    check("cam_fall_wait_e3", 3'b010);
    tick(); check("cam_fall_e4", 3'b000);
    camera_raw = 1'b1;
    repeat (3) tick();
    check("cam_glitch_e3", 3'b000);
    camera_raw = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(); check($sformatf("cam_glitch_after_e%0d", k), 3'b000);
    end

    // Both channels rise together.
    camera_raw = 1'b1; radar_raw = 1'b1;
    repeat (3) tick();
    check("both_rise_wait_e3", 3'b000);
    tick(); check("both_rise_e4", 3'b011);

    // error_clear in OK is ignored.
    error_clear = 1'b1; tick(); error_clear = 1'b0;
    check("clear_ignored_ok", 3'b011);

    // Radar heartbeat loss: FAULT on the 9th edge after the last pulse edge.
    tick_to_pulse();
    rad_hb_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(); check($sformatf("radar_dead_e%0d", k), 3'b011);
    end
    tick(); check("radar_timeout_e9", 3'b100);

    // error_clear while the timeout persists keeps FAULT.
    error_clear = 1'b1; tick(); error_clear = 1'b0;
    check("clear_with_timeout", 3'b100);
    tick(); check("fault_hold", 3'b100);

    // Heartbeats resume, clear -> RECOVER -> OK after 4 edges.
    rad_hb_en = 1'b1;
    tick_to_pulse();
    check("fault_hb_back", 3'b100);
    error_clear = 1'b1; tick(); error_clear = 1'b0;
    check("clear_to_recover", 3'b100);
    for (int k = 1; k <= 3; k++) begin
      tick(); check($sformatf("recover_e%0d", k), 3'b100);
    end
    tick(); check("recover_ok_e4", 3'b011);

    // Camera timeout into FAULT, then stage a timeout on the 3rd RECOVER edge.
    tick_to_pulse();
    cam_hb_en = 1'b0;
    repeat (8) tick();
    check("cam_dead_e8", 3'b011);
    tick(); check("cam_timeout_e9", 3'b100);
    cam_hb_en = 1'b1;
    tick_to_pulse();
    cam_hb_en = 1'b0;
    repeat (5) tick();
    check("cam_wd5_fault", 3'b100);
    error_clear = 1'b1; tick(); error_clear = 1'b0;
    check("cam_clear_recover", 3'b100);
    for (int k = 1; k <= 3; k++) begin
      tick(); check($sformatf("recover_timeout_e%0d", k), 3'b100);
    end
    cam_hb_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(); check($sformatf("refault_hold_e%0d", k), 3'b100);
    end
    error_clear = 1'b1; tick(); error_clear = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); check($sformatf("rerecover_e%0d", k), 3'b100);
    end
    tick(); check("rerecover_ok_e4", 3'b011);

    // Reset asserted mid-debounce takes effect without a clock edge.
    camera_raw = 1'b0;
    repeat (2) tick();
    check("mid_debounce_ok", 3'b011);
    #2 reset = 1'b1;
    #1 check("reset_mid_async", 3'b100);
    repeat (2) tick();
    check("reset_mid_held", 3'b100);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); check($sformatf("post_reset_recover_e%0d", k), 3'b100);
    end
    tick(); check("post_reset_ok_e4", 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
